bus_responder: RTL and testbench

//  Remote end of the serial bus transaction. Waits for a 1-byte request from the
//  bus master on the UART receiver and decodes it as {CMD_PREFIX, index}.

---
 rtl/bus_responder_if.sv | 27 ++
 rtl/bus_responder.sv | 172 +++++++++++++++++
 tb/tb_bus_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// Serial-bus responder signal bundle: UART rx/tx handshakes, register bank and status.
// slave = the responder side, master = UART cores / register bank / monitor side.
interface bus_responder_if #(
    parameter int unsigned NUM_REGS = 4
) ();
    logic [7:0]            data_rx;
    logic                  done_rx;
    logic                  resetn_rx;
    logic                  done_tx;
    logic                  resetn_tx;
    logic                  enable_tx;
    logic [7:0]            data_tx;
    logic [NUM_REGS*8-1:0] reg_data;
    logic                  busy;
    logic                  cmd_valid;
    logic [7:0]            last_cmd;

    modport slave (
        input  data_rx, done_rx, done_tx, reg_data,
        output resetn_rx, resetn_tx, enable_tx, data_tx, busy, cmd_valid, last_cmd
    );

    modport master (
        output data_rx, done_rx, done_tx, reg_data,
        input  resetn_rx, resetn_tx, enable_tx, data_tx, busy, cmd_valid, last_cmd
    );
endinterface

// File: rtl/bus_responder.sv
// Remote end of the serial bus: decodes a 1-byte request, replies with a register byte and its CRC-8.
// Define RESP_NACK_EN to answer invalid requests with 8'hFF + CRC instead of dropping them.
module bus_responder #(
    parameter logic [7:0]  KEY        = 8'h37,
    parameter int unsigned NUM_REGS   = 4,
    parameter logic [3:0]  CMD_PREFIX = 4'hA
) (
    input logic            clock,
    input logic            resetn,
    bus_responder_if.slave bus
);
    typedef enum logic [2:0] {
        RX_RST  = 3'd0,
        RX_WAIT = 3'd1,
        DECODE  = 3'd2,
        CRC     = 3'd3,
        TX_RST  = 3'd4,
        TX_EN   = 3'd5,
        TX_WAIT = 3'd6
    } state_e;

    typedef enum logic {
        PH_DATA = 1'b0,
        PH_CRC  = 1'b1
    } phase_e;

    state_e     state_q, state_d;
    phase_e     phase_q, phase_d;
    logic [7:0] req_q, req_d;
    logic [7:0] crc_q, crc_d;
    logic [2:0] cnt_q, cnt_d;
    logic       resetn_rx_q, resetn_rx_d;
    logic       resetn_tx_q, resetn_tx_d;
    logic       enable_tx_q, enable_tx_d;
    logic [7:0] data_tx_q, data_tx_d;
    logic       busy_q, busy_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] last_cmd_q, last_cmd_d;

    logic [7:0] sel_byte;
    logic       req_valid;
    logic       crc_bit;

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (req_q[3:0] == i[3:0]) sel_byte = bus.reg_data[8*i +: 8];
        end
    end

    assign req_valid = (req_q[7:4] == CMD_PREFIX) && (32'(req_q[3:0]) < NUM_REGS);
    assign crc_bit   = data_tx_q[3'd7 - cnt_q];

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        req_d       = req_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        resetn_rx_d = resetn_rx_q;
        resetn_tx_d = resetn_tx_q;
        enable_tx_d = enable_tx_q;
        data_tx_d   = data_tx_q;
        busy_d      = busy_q;
        cmd_valid_d = 1'b0;
        last_cmd_d  = last_cmd_q;

        case (state_q)
            RX_RST: begin
                resetn_rx_d = 1'b0;
                state_d     = RX_WAIT;
            end
            RX_WAIT: begin
                resetn_rx_d = 1'b1;
                if (bus.done_rx) begin
                    req_d   = bus.data_rx;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (req_valid) begin
                    // Snapshot the register so later bank updates cannot corrupt the reply.
                    data_tx_d   = sel_byte;
                    last_cmd_d  = req_q;
                    cmd_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    crc_d       = '0;
                    cnt_d       = '0;
                    phase_d     = PH_DATA;
                    state_d     = CRC;
                end else begin
`ifdef RESP_NACK_EN
                    data_tx_d = 8'hFF;
                    busy_d    = 1'b1;
                    crc_d     = '0;
                    cnt_d     = '0;
                    phase_d   = PH_DATA;
                    state_d   = CRC;
`else
                    state_d = RX_RST;
`endif
                end
            end
            CRC: begin
                crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ crc_bit) ? KEY : 8'h00);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = TX_RST;
            end
            TX_RST: begin
                resetn_tx_d = 1'b0;
                state_d     = TX_EN;
            end
            TX_EN: begin
                resetn_tx_d = 1'b1;
                enable_tx_d = 1'b1;
                state_d     = TX_WAIT;
            end
            TX_WAIT: begin
                enable_tx_d = 1'b0;
                if (bus.done_tx) begin
                    if (phase_q == PH_DATA) begin
                        data_tx_d = crc_q;
                        phase_d   = PH_CRC;
                        state_d   = TX_RST;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = RX_RST;
                    end
                end
            end
            default: state_d = RX_RST;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RX_RST;
            phase_q     <= PH_DATA;
            req_q       <= '0;
            crc_q       <= '0;
            cnt_q       <= '0;
            resetn_rx_q <= 1'b1;
            resetn_tx_q <= 1'b1;
            enable_tx_q <= 1'b0;
            data_tx_q   <= '0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            last_cmd_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            req_q       <= req_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            resetn_rx_q <= resetn_rx_d;
            resetn_tx_q <= resetn_tx_d;
            enable_tx_q <= enable_tx_d;
            data_tx_q   <= data_tx_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    assign bus.resetn_rx = resetn_rx_q;
    assign bus.resetn_tx = resetn_tx_q;
    assign bus.enable_tx = enable_tx_q;
    assign bus.data_tx   = data_tx_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.last_cmd  = last_cmd_q;
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder with simple UART rx/tx behavioural models.
// Expectations follow RESP_NACK_EN when the bench is built with it defined.
module tb_bus_responder;
    logic clock;
    logic resetn;

    bus_responder_if #(.NUM_REGS(4)) bus ();

    bus_responder #(
        .KEY        (8'h37),
        .NUM_REGS   (4),
        .CMD_PREFIX (4'hA)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  tx_q[$];
    int unsigned en_count;
    int unsigned cv_count;
    int unsigned ncyc;
    int unsigned first_en_ncyc;
    int unsigned done_ncyc;
    int unsigned last_gap;
    int unsigned start_ncyc;
    int          ack_timer;
    bit          auto_ack;
    bit          prev_en;

    // Receiver/transmitter models plus pulse monitor, all evaluated away from the active edge.
    always @(negedge clock) begin
        ncyc++;
        if (!bus.resetn_rx) bus.done_rx = 1'b0;
        if (!bus.resetn_tx) bus.done_tx = 1'b0;
        if (bus.cmd_valid) cv_count++;
        if (bus.enable_tx) begin
            check("en_consecutive", {31'b0, prev_en}, 32'd0);
            tx_q.push_back(bus.data_tx);
            en_count++;
            if (en_count == 1) first_en_ncyc = ncyc;
            else last_gap = ncyc - done_ncyc;
            if (auto_ack) ack_timer = 4;
        end else if (ack_timer > 0) begin
            ack_timer--;
            if (ack_timer == 0) begin
                bus.done_tx = 1'b1;
                done_ncyc   = ncyc;
            end
        end
        prev_en = bus.enable_tx;
    end

    task automatic clear_mon();
        tx_q.delete();
        en_count = 0;
        cv_count = 0;
        last_gap = 0;
    endtask

    task automatic send_req(input logic [7:0] b);
        @(negedge clock);
        #1;
        bus.data_rx = b;
        bus.done_rx = 1'b1;
        start_ncyc  = ncyc;
    endtask

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while (bus.busy && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check("idle_timeout", {31'b0, bus.busy}, 32'd0);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resetn_rx"}, {31'b0, bus.resetn_rx}, 32'd1);
        check({tag, "_resetn_tx"}, {31'b0, bus.resetn_tx}, 32'd1);
        check({tag, "_enable_tx"}, {31'b0, bus.enable_tx}, 32'd0);
        check({tag, "_data_tx"},   {24'b0, bus.data_tx},   32'h00);
        check({tag, "_busy"},      {31'b0, bus.busy},      32'd0);
        check({tag, "_cmd_valid"}, {31'b0, bus.cmd_valid}, 32'd0);
        check({tag, "_last_cmd"},  {24'b0, bus.last_cmd},  32'h00);
    endtask

    initial begin
        resetn       = 1'b0;
        bus.data_rx  = '0;
        bus.done_rx  = 1'b0;
        bus.done_tx  = 1'b0;
        bus.reg_data = {8'h00, 8'h80, 8'h01, 8'h02};
        auto_ack     = 1'b1;
        ack_timer    = 0;
        prev_en      = 1'b0;
        ncyc         = 0;
        clear_mon();

        repeat (3) @(negedge clock);
        check_reset_outputs("por");
        resetn = 1'b1;
        repeat (4) @(negedge clock);

        // Valid read of reg1: 8'h01 then CRC 8'h37, with latency checks.
        clear_mon();
        send_req(8'hA1);
        repeat (4) @(negedge clock);
        check("a1_busy_high", {31'b0, bus.busy}, 32'd1);
        wait_idle();
        check("a1_first_latency", first_en_ncyc - start_ncyc, 32'd12);
        check("a1_second_gap", last_gap, 32'd3);
        check("a1_en_count", en_count, 32'd2);
        check("a1_byte0", {24'b0, tx_q[0]}, 32'h01);
        check("a1_byte1", {24'b0, tx_q[1]}, 32'h37);
        check("a1_cmd_valid_cycles", cv_count, 32'd1);
        check("a1_last_cmd", {24'b0, bus.last_cmd}, 32'hA1);

        // Async reset in the middle of the CRC: outputs clear at once, reply dropped.
        clear_mon();
        send_req(8'hA1);
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midcrc");
        @(negedge clock);
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        check("midcrc_no_tx", en_count, 32'd0);
        check("midcrc_busy", {31'b0, bus.busy}, 32'd0);

        // Reg2 snapshot: bank changes during CRC must not affect the reply.
        clear_mon();
        send_req(8'hA2);
        repeat (5) @(negedge clock);
        bus.reg_data[23:16] = 8'h55;
        wait_idle();
        check("a2_en_count", en_count, 32'd2);
        check("a2_byte0", {24'b0, tx_q[0]}, 32'h80);
        check("a2_byte1", {24'b0, tx_q[1]}, 32'h7F);
        check("a2_last_cmd", {24'b0, bus.last_cmd}, 32'hA2);

        // Transmitter never finishes: exactly one start pulse, still busy.
        clear_mon();
        auto_ack = 1'b0;
        send_req(8'hA1);
        repeat (100) @(negedge clock);
        check("hold_busy", {31'b0, bus.busy}, 32'd1);
        check("hold_en_count", en_count, 32'd1);
        check("hold_byte0", {24'b0, tx_q[0]}, 32'h01);
        #1;
        auto_ack    = 1'b1;
        bus.done_tx = 1'b1;
        wait_idle();
        check("hold_resume_count", en_count, 32'd2);
        check("hold_resume_byte1", {24'b0, tx_q[1]}, 32'h37);

        // Bad prefix.
        clear_mon();
        send_req(8'h51);
        repeat (30) @(negedge clock);
        wait_idle();
        check("bad_cmd_valid", cv_count, 32'd0);
        check("bad_last_cmd", {24'b0, bus.last_cmd}, 32'hA1);
        check("bad_busy", {31'b0, bus.busy}, 32'd0);
`ifdef RESP_NACK_EN
        check("bad_en_count", en_count, 32'd2);
        check("bad_byte0", {24'b0, tx_q[0]}, 32'hFF);
        check("bad_byte1", {24'b0, tx_q[1]}, 32'hAA);
`else
        check("bad_en_count", en_count, 32'd0);
`endif

        // Out-of-range index followed by a valid read of reg0 (8'h02, CRC 8'h6E).
        clear_mon();
        send_req(8'hA7);
        repeat (30) @(negedge clock);
        wait_idle();
        send_req(8'hA0);
        repeat (4) @(negedge clock);
        wait_idle();
        check("idx_cmd_valid", cv_count, 32'd1);
        check("idx_last_cmd", {24'b0, bus.last_cmd}, 32'hA0);
`ifdef RESP_NACK_EN
        check("idx_en_count", en_count, 32'd4);
        check("idx_nack0", {24'b0, tx_q[0]}, 32'hFF);
        check("idx_nack1", {24'b0, tx_q[1]}, 32'hAA);
        check("idx_byte0", {24'b0, tx_q[2]}, 32'h02);
        check("idx_byte1", {24'b0, tx_q[3]}, 32'h6E);
`else
        check("idx_en_count", en_count, 32'd2);
        check("idx_byte0", {24'b0, tx_q[0]}, 32'h02);
        check("idx_byte1", {24'b0, tx_q[1]}, 32'h6E);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
